ysyx_24100029_ifu_fetch: RTL and testbench

YSYX_24100029_IFU_FETCH -- requirements
Module: ysyx_24100029_ifu_fetch

---
 rtl/ysyx_24100029_ifu_pkg.sv | 17 +
 rtl/ysyx_24100029_ifu_linebuf.sv | 66 ++++++
 rtl/ysyx_24100029_ifu_fetch.sv | 142 ++++++++++++++
 tb/tb_ysyx_24100029_ifu_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100029_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// line-offset arithmetic used by the fetch top and its line buffer.
package ysyx_24100029_ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_DROP = 2'd3
  } ifu_state_e;

  // Byte-offset bits inside one icache line.
  function automatic int ifu_line_off(input int line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/ysyx_24100029_ifu_linebuf.sv
// Single-line instruction buffer: holds the last icache line and selects the
// 32-bit word for the current pc. Tag store/compare exist only with IFU_LINE_BUF_EN.
module ysyx_24100029_ifu_linebuf
  import ysyx_24100029_ifu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  localparam int LINE_OFF  = ifu_line_off(LINE_WIDTH),
  localparam int WSEL_W    = LINE_OFF - 2,
  localparam int TAG_W     = ADDR_WIDTH - LINE_OFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  capture,
  input  logic                  invalidate,
  input  logic [LINE_WIDTH-1:0] line_in,
  input  logic [WSEL_W-1:0]     word_sel,
`ifdef IFU_LINE_BUF_EN
  input  logic [TAG_W-1:0]      capture_tag,
  input  logic [TAG_W-1:0]      probe_tag,
  output logic                  hit,
`endif
  output logic [31:0]           word
);

  logic [LINE_WIDTH-1:0] data_r;
  logic                  valid_r;

  // Line data register, loaded on a fresh icache response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_r <= '0;
    end else if (capture) begin
      data_r <= line_in;
    end
  end

  // Valid flag; invalidation (fence.i) takes priority over capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
    end else if (invalidate) begin
      valid_r <= 1'b0;
    end else if (capture) begin
      valid_r <= 1'b1;
    end
  end

  assign word = valid_r ? data_r[{word_sel, 5'd0} +: 32] : 32'h0000_0000;

`ifdef IFU_LINE_BUF_EN
  logic [TAG_W-1:0] tag_r;

  // Tag of the buffered line, used to serve sequential fetches locally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_r <= '0;
    end else if (capture) begin
      tag_r <= capture_tag;
    end
  end

  assign hit = valid_r & (probe_tag == tag_r);
`endif

endmodule

// File: rtl/ysyx_24100029_ifu_fetch.sv
// Instruction fetch unit: pc register and request/wait/output/drop FSM in front
// of the icache. Define IFU_LINE_BUF_EN to serve same-line sequential fetches from the line buffer.
module ysyx_24100029_ifu_fetch
  import ysyx_24100029_ifu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    LINE_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h3000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  fence_i,
  output logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_arvalid,
  input  logic                  ic_arready,
  output logic                  ic_clr,
  input  logic [LINE_WIDTH-1:0] ic_line,
  input  logic                  ic_rvalid,
  output logic                  ic_rready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [31:0]           out_inst
);

  localparam int LINE_OFF = ifu_line_off(LINE_WIDTH);

  ifu_state_e            state_r;
  ifu_state_e            state_nxt_s;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] pc_nxt_s;
  logic [ADDR_WIDTH-1:0] pc_inc_s;
  logic [ADDR_WIDTH-1:0] req_addr_r;
  logic                  lb_capture_s;
  logic                  lb_hit_s;

  assign pc_inc_s  = pc_r + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
  assign ic_clr    = fence_i & redirect_valid;
  // The icache keeps seeing the accepted address even if a redirect moves pc.
  assign ic_addr   = (state_r == S_REQ) ? pc_r : req_addr_r;
  assign out_valid = (state_r == S_OUT);
  assign out_pc    = pc_r;

  // Next-state, next-pc and handshake outputs; redirect has top priority.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    ic_arvalid   = 1'b0;
    ic_rready    = 1'b0;
    lb_capture_s = 1'b0;
    case (state_r)
      S_REQ: begin
        ic_arvalid = ~redirect_valid;
        if (redirect_valid) begin
          pc_nxt_s = redirect_pc;
        end else if (ic_arready) begin
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        ic_rready = 1'b1;
        if (redirect_valid) begin
          pc_nxt_s = redirect_pc;
          // A response arriving alongside the redirect is consumed and discarded here.
          state_nxt_s = ic_rvalid ? S_REQ : S_DROP;
        end else if (ic_rvalid) begin
          lb_capture_s = 1'b1;
          state_nxt_s  = S_OUT;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_nxt_s    = redirect_pc;
          state_nxt_s = S_REQ;
        end else if (out_ready) begin
          pc_nxt_s    = pc_inc_s;
          state_nxt_s = lb_hit_s ? S_OUT : S_REQ;
        end else begin
          state_nxt_s = S_OUT;
        end
      end
      S_DROP: begin
        ic_rready = 1'b1;
        if (redirect_valid) begin
          pc_nxt_s    = redirect_pc;
          state_nxt_s = ic_rvalid ? S_REQ : S_DROP;
        end else if (ic_rvalid) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_DROP;
        end
      end
      default: begin
        state_nxt_s = S_REQ;
      end
    endcase
  end

  // State, pc and the address latched while a request is in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= S_REQ;
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (state_r == S_REQ) begin
        req_addr_r <= pc_r;
      end
    end
  end

  ysyx_24100029_ifu_linebuf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_linebuf (
    .clock       (clock),
    .reset       (reset),
    .capture     (lb_capture_s),
    .invalidate  (ic_clr),
    .line_in     (ic_line),
    .word_sel    (pc_r[LINE_OFF-1:2]),
`ifdef IFU_LINE_BUF_EN
    .capture_tag (pc_r[ADDR_WIDTH-1:LINE_OFF]),
    .probe_tag   (pc_inc_s[ADDR_WIDTH-1:LINE_OFF]),
    .hit         (lb_hit_s),
`endif
    .word        (out_inst)
  );

`ifndef IFU_LINE_BUF_EN
  assign lb_hit_s = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24100029_ifu_fetch.sv
// Randomized self-checking bench for ysyx_24100029_ifu_fetch with an
// instruction-level reference model and a behavioural icache.
module tb_ysyx_24100029_ifu_fetch;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         fence_i = 1'b0;
  logic [31:0]  ic_addr;
  logic         ic_arvalid;
  logic         ic_arready = 1'b0;
  logic         ic_clr;
  logic [127:0] ic_line = '0;
  logic         ic_rvalid = 1'b0;
  logic         ic_rready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_pc;
  logic [31:0]  out_inst;

  int tests = 0;
  int fails = 0;

  // Reference model: architectural pc, instruction available, request in flight.
  logic [31:0] mpc = 32'h3000_0000;
  bit          avail = 1'b0;
  bit          outst = 1'b0;
  bit          stale = 1'b0;
  logic [31:0] out_addr = 32'h0;
  int          wait_cnt = 0;
`ifdef IFU_LINE_BUF_EN
  bit          lb_v = 1'b0;
  logic [27:0] lb_tag = '0;
`endif

  logic [31:0] acc_q[$];
  logic [31:0] hs_q[$];

  ysyx_24100029_ifu_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fence_i        (fence_i),
    .ic_addr        (ic_addr),
    .ic_arvalid     (ic_arvalid),
    .ic_arready     (ic_arready),
    .ic_clr         (ic_clr),
    .ic_line        (ic_line),
    .ic_rvalid      (ic_rvalid),
    .ic_rready      (ic_rready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C ^ (a << 3);
  endfunction

  function automatic logic [127:0] make_line(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = a & 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = mem_word(base + 32'(4 * i));
    return l;
  endfunction

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 3))
      0:       return $urandom() & 32'hFFFF_FFFC;
      1:       return 32'h3000_0000 + 32'($urandom_range(0, 15) << 2);
      2:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) << 2);
      default: return 32'h8000_0000 + 32'($urandom_range(0, 31) << 2);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mpc = 32'h3000_0000; avail = 1'b0; outst = 1'b0; stale = 1'b0; wait_cnt = 0;
`ifdef IFU_LINE_BUF_EN
    lb_v = 1'b0;
`endif
  endtask

  // One clock cycle: drive, check every output against the model, advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit fen,
                      input bit ordy, input bit arrdy, input bit rv_en, input int lat);
    bit exp_arv, acc, hs, resp;
    logic [31:0] old_pc;
    @(negedge clock);
    redirect_valid = redir; redirect_pc = rpc; fence_i = fen;
    out_ready = ordy; ic_arready = arrdy;
    ic_rvalid = outst && rv_en && (wait_cnt == 0);
    if (ic_rvalid) ic_line = make_line(out_addr);
    else for (int i = 0; i < 4; i++) ic_line[32*i +: 32] = $urandom();
    #1;
    exp_arv = !avail && !outst && !redir;
    chk("ic_clr", {31'b0, ic_clr}, {31'b0, fen & redir});
    chk("ic_rready", {31'b0, ic_rready}, {31'b0, outst});
    chk("out_valid", {31'b0, out_valid}, {31'b0, avail});
    chk("ic_arvalid", {31'b0, ic_arvalid}, {31'b0, exp_arv});
    if (avail) begin
      chk("out_pc", out_pc, mpc);
      chk("out_inst", out_inst, mem_word(mpc));
    end
    if (exp_arv) chk("ic_addr_req", ic_addr, mpc);
    if (outst) chk("ic_addr_hold", ic_addr, out_addr);
    if (ic_arvalid && arrdy) acc_q.push_back(ic_addr);
    if (out_valid && ordy && !redir) hs_q.push_back(out_pc);

    acc = exp_arv && arrdy;
    hs = avail && ordy;
    resp = ic_rvalid;
    old_pc = mpc;
    if (resp) begin
      outst = 1'b0;
      if (!stale && !redir) begin
        avail = 1'b1;
`ifdef IFU_LINE_BUF_EN
        lb_v = 1'b1; lb_tag = out_addr[31:4];
`endif
      end
    end else if (outst && wait_cnt > 0) begin
      wait_cnt--;
    end
    if (redir) begin
      mpc = rpc; avail = 1'b0;
      if (outst) stale = 1'b1;
`ifdef IFU_LINE_BUF_EN
      if (fen) lb_v = 1'b0;
`endif
    end else if (hs) begin
      mpc = mpc + 32'd4; avail = 1'b0;
`ifdef IFU_LINE_BUF_EN
      if (lb_v && mpc[31:4] == lb_tag) avail = 1'b1;
`endif
    end
    if (acc) begin
      outst = 1'b1; out_addr = old_pc; stale = 1'b0; wait_cnt = lat;
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_ic_rready", {31'b0, ic_rready}, 32'h0);
    chk("rst_ic_clr", {31'b0, ic_clr}, 32'h0);
    chk("rst_ic_addr", ic_addr, 32'h3000_0000);
    @(negedge clock);
    reset = 1'b0;

    // Always-hit icache, decode always ready.
    for (int i = 0; i < 12; i++) step(0, 32'h0, 0, 1, 1, 1, 0);
    chk("first_req", q_at(acc_q, 0), 32'h3000_0000);
    chk("seq0", q_at(hs_q, 0), 32'h3000_0000);
    chk("seq1", q_at(hs_q, 1), 32'h3000_0004);
    chk("seq2", q_at(hs_q, 2), 32'h3000_0008);

    // Decode stall: model checks pc/inst held and no new request.
    for (int i = 0; i < 20 && !avail; i++) step(0, 32'h0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 0, 1, 1, 0);

    // Redirect while a slow (miss) response is outstanding.
    step(0, 32'h0, 0, 1, 1, 1, 5);
    step(0, 32'h0, 0, 1, 1, 1, 5);
    acc_q.delete(); hs_q.delete();
    step(1, 32'h8000_0040, 0, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 32'h0, 0, 1, 1, 1, 0);
    chk("redir_req", q_at(acc_q, 0), 32'h8000_0040);
    chk("redir_out", q_at(hs_q, 0), 32'h8000_0040);

    // fence.i with redirect: refetch goes back to the icache.
    acc_q.delete();
    step(1, 32'h3000_0004, 1, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 32'h0, 0, 1, 1, 1, 0);
    chk("fence_req", q_at(acc_q, 0), 32'h3000_0004);

    // pc wrap-around.
    hs_q.delete();
    step(1, 32'hFFFF_FFFC, 0, 1, 1, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 32'h0, 0, 1, 1, 1, 0);
    chk("wrap0", q_at(hs_q, 0), 32'hFFFF_FFFC);
    chk("wrap1", q_at(hs_q, 1), 32'h0000_0000);

    // Asynchronous reset while waiting on the icache.
    for (int i = 0; i < 20 && !avail; i++) step(0, 32'h0, 0, 0, 1, 1, 0);
    step(0, 32'h0, 0, 1, 1, 1, 6);
    step(0, 32'h0, 0, 1, 1, 1, 6);
    @(negedge clock);
    redirect_valid = 1'b0; fence_i = 1'b0; ic_arready = 1'b0; ic_rvalid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_ic_rready", {31'b0, ic_rready}, 32'h0);
    chk("arst_ic_addr", ic_addr, 32'h3000_0000);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 6; i++) step(0, 32'h0, 0, 1, 1, 1, 0);
    chk("arst_refetch", q_at(acc_q, 0), 32'h3000_0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) == 0, rand_pc(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
